// File: rtl/exception_pkg.sv
// rtl/exception_pkg.sv - shared cause codes, vector offsets and FSM encoding for exception_ctrl
package exception_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_CPU  = 5'h0b;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam logic [31:0] VEC_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_GENERAL = 32'h0000_0180;
    localparam logic [31:0] VEC_INT     = 32'h0000_0200;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_WAIT = 2'd2
    } exc_state_e;

    // Everything captured at the commit edge except the ASID, whose width is a parameter.
    typedef struct packed {
        logic        in_exp;
        logic        clean_exl;
        logic        badv_we;
        logic        asid_we;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] badv;
        logic [31:0] new_pc;
    } commit_t;

    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic delayslot);
        return delayslot ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/int_vec_calc.sv
// rtl/int_vec_calc.sv - priority-encodes the pending interrupt vector into a vectored handler offset
module int_vec_calc
    import exception_pkg::*;
#(
    parameter int IP_W = 8
) (
    input  logic [IP_W-1:0] i_ip,
    input  logic            i_vint_en,
    input  logic [4:0]      i_vint_spacing,
    output logic [31:0]     o_vec_offset
);

    localparam int IDX_W = $clog2(IP_W);

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_step;

    // Ascending scan: the highest set bit is the last one to write w_idx.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < IP_W; i++) begin
            if (i_ip[i]) begin
                w_idx = IDX_W'(i);
            end
        end
        if (!i_vint_en) begin
            w_idx = '0;
        end
        w_step       = {22'd0, i_vint_spacing, 5'd0};
        o_vec_offset = VEC_INT + (32'(w_idx) * w_step);
    end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - registered exception/interrupt arbiter issuing one commit pulse per redirect
module exception_ctrl
    import exception_pkg::*;
#(
    parameter int          NUM_HW_INT    = 6,
    parameter int          ASID_W        = 8,
    parameter logic [31:0] BOOT_EXP_BASE = 32'hBFC00200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            fetch_exp,
    input  logic [3:0]            data_exp,
    input  logic                  data_we,
    input  logic                  syscall,
    input  logic                  invalid_inst,
    input  logic                  restrict_priv_inst,
    input  logic                  overflow,
    input  logic                  eret,
    input  logic [NUM_HW_INT-1:0] hardware_int,
    input  logic [1:0]            software_int,
    input  logic [NUM_HW_INT+1:0] interrupt_mask,
    input  logic                  allow_int,
    input  logic                  is_real_inst,
    input  logic [31:0]           pc_value,
    input  logic                  in_delayslot,
    input  logic [31:0]           mem_access_vaddr,
    input  logic [ASID_W-1:0]     if_asid,
    input  logic [ASID_W-1:0]     mm_asid,
    input  logic [19:0]           ebase_in,
    input  logic [31:0]           epc_in,
    input  logic                  special_int_vec,
    input  logic                  boot_exp_vec,
    input  logic                  if_exl,
    input  logic                  mm_exl,
    input  logic                  vint_en,
    input  logic [4:0]            vint_spacing,
    input  logic                  pipe_ready,
    output logic                  flush,
    output logic                  exp_valid,
    output logic                  cp0_in_exp,
    output logic                  cp0_clean_exl,
    output logic                  cp0_badv_we,
    output logic                  cp0_exp_asid_we,
    output logic [4:0]            exp_code,
    output logic [31:0]           exp_epc,
    output logic [31:0]           exp_bad_vaddr,
    output logic [31:0]           exception_new_pc,
    output logic [ASID_W-1:0]     exp_asid,
    output logic                  busy
);

    localparam int IP_W = NUM_HW_INT + 2;

    exc_state_e            r_state;
    logic [NUM_HW_INT-1:0] r_sync;
    logic [NUM_HW_INT-1:0] r_int_pend;
    logic                  r_flush;
    logic                  r_exp_valid;
    logic                  r_in_exp;
    logic                  r_clean_exl;
    logic                  r_badv_we;
    logic                  r_asid_we;
    logic [4:0]            r_code;
    logic [31:0]           r_epc;
    logic [31:0]           r_badv;
    logic [31:0]           r_new_pc;
    logic [ASID_W-1:0]     r_asid;
    logic                  r_busy;

    logic [IP_W-1:0]       w_ip;
    logic                  w_int_ok;
    logic [31:0]           w_base;
    logic [31:0]           w_vec_off;
    commit_t               w_cm;
    logic [ASID_W-1:0]     w_asid;
    logic                  w_event;

    int_vec_calc #(
        .IP_W (IP_W)
    ) u_int_vec_calc (
        .i_ip           (w_ip),
        .i_vint_en      (vint_en),
        .i_vint_spacing (vint_spacing),
        .o_vec_offset   (w_vec_off)
    );

    assign w_ip     = {r_int_pend, software_int} & interrupt_mask;
    assign w_int_ok = is_real_inst && allow_int && (w_ip != '0);
    assign w_base   = boot_exp_vec ? BOOT_EXP_BASE : {ebase_in, 12'h000};

    // Fixed-priority arbitration; the first matching branch owns the commit record.
    always_comb begin
        w_cm           = '0;
        w_cm.in_exp    = 1'b1;
        w_cm.epc       = epc_of(pc_value, in_delayslot);
        w_cm.new_pc    = w_base + VEC_GENERAL;
        w_asid         = '0;
        w_event        = 1'b1;
        if (w_int_ok) begin
            w_cm.code = EXC_INT;
            if (special_int_vec) begin
                w_cm.new_pc = w_base + w_vec_off;
            end
        end else if (fetch_exp[2]) begin
            w_cm.code    = EXC_ADEL;
            w_cm.badv    = pc_value;
            w_cm.badv_we = 1'b1;
        end else if (fetch_exp[1] || fetch_exp[0]) begin
            w_cm.code    = EXC_TLBL;
            w_cm.badv    = pc_value;
            w_cm.badv_we = 1'b1;
            w_cm.asid_we = 1'b1;
            w_asid       = if_asid;
            if (fetch_exp[1] && !if_exl) begin
                w_cm.new_pc = w_base + VEC_REFILL;
            end
        end else if (data_exp[3]) begin
            w_cm.code    = data_we ? EXC_ADES : EXC_ADEL;
            w_cm.badv    = mem_access_vaddr;
            w_cm.badv_we = 1'b1;
        end else if (data_exp[2] || data_exp[1]) begin
            w_cm.code    = data_we ? EXC_TLBS : EXC_TLBL;
            w_cm.badv    = mem_access_vaddr;
            w_cm.badv_we = 1'b1;
            w_cm.asid_we = 1'b1;
            w_asid       = mm_asid;
            if (data_exp[2] && !mm_exl) begin
                w_cm.new_pc = w_base + VEC_REFILL;
            end
        end else if (data_exp[0]) begin
            w_cm.code    = EXC_MOD;
            w_cm.badv    = mem_access_vaddr;
            w_cm.badv_we = 1'b1;
            w_cm.asid_we = 1'b1;
            w_asid       = mm_asid;
        end else if (syscall) begin
            w_cm.code = EXC_SYS;
        end else if (invalid_inst) begin
            w_cm.code = EXC_RI;
        end else if (restrict_priv_inst) begin
            w_cm.code = EXC_CPU;
        end else if (overflow) begin
            w_cm.code = EXC_OV;
        end else if (eret) begin
            w_cm.code      = EXC_INT;
            w_cm.in_exp    = 1'b0;
            w_cm.clean_exl = 1'b1;
            w_cm.new_pc    = epc_in;
        end else begin
            w_event = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sync      <= '0;
            r_int_pend  <= '0;
            r_flush     <= 1'b0;
            r_exp_valid <= 1'b0;
            r_in_exp    <= 1'b0;
            r_clean_exl <= 1'b0;
            r_badv_we   <= 1'b0;
            r_asid_we   <= 1'b0;
            r_code      <= '0;
            r_epc       <= '0;
            r_badv      <= '0;
            r_new_pc    <= '0;
            r_asid      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_sync     <= hardware_int;
            r_int_pend <= r_sync;
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        r_state     <= ST_TAKE;
                        r_busy      <= 1'b1;
                        r_flush     <= 1'b1;
                        r_exp_valid <= 1'b1;
                        r_in_exp    <= w_cm.in_exp;
                        r_clean_exl <= w_cm.clean_exl;
                        r_badv_we   <= w_cm.badv_we;
                        r_asid_we   <= w_cm.asid_we;
                        r_code      <= w_cm.code;
                        r_epc       <= w_cm.epc;
                        r_badv      <= w_cm.badv;
                        r_new_pc    <= w_cm.new_pc;
                        r_asid      <= w_asid;
                    end
                end
                ST_TAKE: begin
                    // Strobes drop after one cycle; the data fields stay visible while waiting.
                    r_state     <= ST_WAIT;
                    r_flush     <= 1'b0;
                    r_exp_valid <= 1'b0;
                    r_in_exp    <= 1'b0;
                    r_clean_exl <= 1'b0;
                    r_badv_we   <= 1'b0;
                    r_asid_we   <= 1'b0;
                end
                ST_WAIT: begin
                    if (pipe_ready) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign flush            = r_flush;
    assign exp_valid        = r_exp_valid;
    assign cp0_in_exp       = r_in_exp;
    assign cp0_clean_exl    = r_clean_exl;
    assign cp0_badv_we      = r_badv_we;
    assign cp0_exp_asid_we  = r_asid_we;
    assign exp_code         = r_code;
    assign exp_epc          = r_epc;
    assign exp_bad_vaddr    = r_badv;
    assign exception_new_pc = r_new_pc;
    assign exp_asid         = r_asid;
    assign busy             = r_busy;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl with an event-list reference model
module tb_exception_ctrl;

    localparam int NHW = 6;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] new_pc;
        logic [31:0] epc;
        logic [31:0] badv;
        logic [7:0]  asid;
        logic        in_exp;
        logic        clean;
        logic        badv_we;
        logic        asid_we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] fetch_exp;
    logic [3:0] data_exp;
    logic data_we, syscall, invalid_inst, restrict_priv_inst, overflow, eret;
    logic [NHW-1:0] hardware_int;
    logic [1:0] software_int;
    logic [NHW+1:0] interrupt_mask;
    logic allow_int, is_real_inst;
    logic [31:0] pc_value;
    logic in_delayslot;
    logic [31:0] mem_access_vaddr;
    logic [7:0] if_asid, mm_asid;
    logic [19:0] ebase_in;
    logic [31:0] epc_in;
    logic special_int_vec, boot_exp_vec, if_exl, mm_exl, vint_en;
    logic [4:0] vint_spacing;
    logic pipe_ready;
    logic flush, exp_valid, cp0_in_exp, cp0_clean_exl, cp0_badv_we, cp0_exp_asid_we;
    logic [4:0] exp_code;
    logic [31:0] exp_epc, exp_bad_vaddr, exception_new_pc;
    logic [7:0] exp_asid;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic       m_busy = 1'b0;
    logic       m_commit = 1'b0;
    logic       m_zero = 1'b1;
    logic [NHW-1:0] m_s1 = '0;
    logic [NHW-1:0] m_pend = '0;
    exp_t       m_exp;
    exp_t       m_r;
    logic       m_hit;

    always #5 clk = ~clk;

    exception_ctrl #(
        .NUM_HW_INT    (NHW),
        .ASID_W        (8),
        .BOOT_EXP_BASE (32'hBFC00200)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_exp          (fetch_exp),
        .data_exp           (data_exp),
        .data_we            (data_we),
        .syscall            (syscall),
        .invalid_inst       (invalid_inst),
        .restrict_priv_inst (restrict_priv_inst),
        .overflow           (overflow),
        .eret               (eret),
        .hardware_int       (hardware_int),
        .software_int       (software_int),
        .interrupt_mask     (interrupt_mask),
        .allow_int          (allow_int),
        .is_real_inst       (is_real_inst),
        .pc_value           (pc_value),
        .in_delayslot       (in_delayslot),
        .mem_access_vaddr   (mem_access_vaddr),
        .if_asid            (if_asid),
        .mm_asid            (mm_asid),
        .ebase_in           (ebase_in),
        .epc_in             (epc_in),
        .special_int_vec    (special_int_vec),
        .boot_exp_vec       (boot_exp_vec),
        .if_exl             (if_exl),
        .mm_exl             (mm_exl),
        .vint_en            (vint_en),
        .vint_spacing       (vint_spacing),
        .pipe_ready         (pipe_ready),
        .flush              (flush),
        .exp_valid          (exp_valid),
        .cp0_in_exp         (cp0_in_exp),
        .cp0_clean_exl      (cp0_clean_exl),
        .cp0_badv_we        (cp0_badv_we),
        .cp0_exp_asid_we    (cp0_exp_asid_we),
        .exp_code           (exp_code),
        .exp_epc            (exp_epc),
        .exp_bad_vaddr      (exp_bad_vaddr),
        .exception_new_pc   (exception_new_pc),
        .exp_asid           (exp_asid),
        .busy               (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t cand(input logic [4:0] code, input logic [31:0] npc, input logic bw,
                                  input logic [31:0] bv, input logic aw, input logic [7:0] as);
        exp_t e;
        e.code    = code;
        e.new_pc  = npc;
        e.epc     = in_delayslot ? pc_value - 32'd4 : pc_value;
        e.badv    = bv;
        e.badv_we = bw;
        e.asid    = as;
        e.asid_we = aw;
        e.in_exp  = 1'b1;
        e.clean   = 1'b0;
        return e;
    endfunction

    // Every active request is listed in priority order; the head of the list wins.
    task automatic arbitrate(input logic [7:0] ip, output logic hit, output exp_t r);
        exp_t q[$];
        exp_t e;
        logic [31:0] base, gen, ipc, idx;
        int hi;
        base = boot_exp_vec ? 32'hBFC00200 : {ebase_in, 12'h000};
        gen  = base + 32'h180;
        hi   = 0;
        for (int b = 0; b < 8; b++) if (ip[b]) hi = b;
        idx  = vint_en ? 32'(hi) : 32'd0;
        ipc  = special_int_vec ? base + 32'h200 + idx * 32'(vint_spacing) * 32'd32 : gen;
        if (is_real_inst && allow_int && ip != 8'h00) q.push_back(cand(5'h00, ipc, 1'b0, 32'h0, 1'b0, 8'h0));
        if (fetch_exp[2]) q.push_back(cand(5'h04, gen, 1'b1, pc_value, 1'b0, 8'h0));
        if (fetch_exp[1]) q.push_back(cand(5'h02, if_exl ? gen : base, 1'b1, pc_value, 1'b1, if_asid));
        if (fetch_exp[0]) q.push_back(cand(5'h02, gen, 1'b1, pc_value, 1'b1, if_asid));
        if (data_exp[3]) q.push_back(cand(data_we ? 5'h05 : 5'h04, gen, 1'b1, mem_access_vaddr, 1'b0, 8'h0));
        if (data_exp[2]) q.push_back(cand(data_we ? 5'h03 : 5'h02, mm_exl ? gen : base, 1'b1, mem_access_vaddr, 1'b1, mm_asid));
        if (data_exp[1]) q.push_back(cand(data_we ? 5'h03 : 5'h02, gen, 1'b1, mem_access_vaddr, 1'b1, mm_asid));
        if (data_exp[0]) q.push_back(cand(5'h01, gen, 1'b1, mem_access_vaddr, 1'b1, mm_asid));
        if (syscall) q.push_back(cand(5'h08, gen, 1'b0, 32'h0, 1'b0, 8'h0));
        if (invalid_inst) q.push_back(cand(5'h0a, gen, 1'b0, 32'h0, 1'b0, 8'h0));
        if (restrict_priv_inst) q.push_back(cand(5'h0b, gen, 1'b0, 32'h0, 1'b0, 8'h0));
        if (overflow) q.push_back(cand(5'h0c, gen, 1'b0, 32'h0, 1'b0, 8'h0));
        if (eret) begin
            e = cand(5'h00, epc_in, 1'b0, 32'h0, 1'b0, 8'h0);
            e.in_exp = 1'b0;
            e.clean  = 1'b1;
            q.push_back(e);
        end
        hit = (q.size() != 0);
        r   = hit ? q[0] : '0;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_commit = 1'b0; m_zero = 1'b1; m_s1 = '0; m_pend = '0;
        end else begin
            if (m_commit) begin
                m_commit = 1'b0;
            end else if (m_busy) begin
                if (pipe_ready) m_busy = 1'b0;
            end else begin
                arbitrate({m_pend, software_int} & interrupt_mask, m_hit, m_r);
                if (m_hit) begin
                    m_commit = 1'b1; m_busy = 1'b1; m_exp = m_r; m_zero = 1'b0;
                end
            end
            m_pend = m_s1;
            m_s1   = hardware_int;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy", busy, m_busy);
        chk("exp_valid", exp_valid, m_commit);
        chk("flush", flush, m_commit);
        if (m_commit) begin
            chk("exp_code", exp_code, m_exp.code);
            chk("new_pc", exception_new_pc, m_exp.new_pc);
            chk("in_exp", cp0_in_exp, m_exp.in_exp);
            chk("clean_exl", cp0_clean_exl, m_exp.clean);
            chk("badv_we", cp0_badv_we, m_exp.badv_we);
            chk("asid_we", cp0_exp_asid_we, m_exp.asid_we);
            if (!m_exp.clean) chk("exp_epc", exp_epc, m_exp.epc);
            if (m_exp.badv_we) chk("bad_vaddr", exp_bad_vaddr, m_exp.badv);
            if (m_exp.asid_we) chk("exp_asid", exp_asid, m_exp.asid);
        end else begin
            chk("strobes_quiet", {cp0_in_exp, cp0_clean_exl, cp0_badv_we, cp0_exp_asid_we}, 32'h0);
            if (m_zero) begin
                chk("zero_code", exp_code, 32'h0);
                chk("zero_epc", exp_epc, 32'h0);
                chk("zero_badv", exp_bad_vaddr, 32'h0);
                chk("zero_pc", exception_new_pc, 32'h0);
                chk("zero_asid", exp_asid, 32'h0);
            end
        end
    end

    task automatic clear_events();
        fetch_exp = '0; data_exp = '0; syscall = 0; invalid_inst = 0; restrict_priv_inst = 0;
        overflow = 0; eret = 0; allow_int = 0; hardware_int = '0; software_int = '0;
    endtask

    task automatic idle_inputs();
        clear_events();
        data_we = 0; interrupt_mask = '0; is_real_inst = 0; pc_value = '0; in_delayslot = 0;
        mem_access_vaddr = '0; if_asid = '0; mm_asid = '0; ebase_in = '0; epc_in = '0;
        special_int_vec = 0; boot_exp_vec = 0; if_exl = 0; mm_exl = 0; vint_en = 0;
        vint_spacing = '0; pipe_ready = 0;
    endtask

    // Called at negedge of a TAKE cycle; returns at negedge+1 with the FSM back in IDLE.
    task automatic release_pipe();
        #1;
        clear_events();
        pipe_ready = 1;
        repeat (2) @(negedge clk);
        #1 pipe_ready = 0;
    endtask

    task automatic randomize_inputs();
        fetch_exp          = ($urandom % 5 == 0) ? 3'($urandom) : 3'b000;
        data_exp           = ($urandom % 5 == 0) ? 4'($urandom) : 4'b0000;
        data_we            = 1'($urandom);
        syscall            = ($urandom % 8 == 0);
        invalid_inst       = ($urandom % 8 == 0);
        restrict_priv_inst = ($urandom % 8 == 0);
        overflow           = ($urandom % 8 == 0);
        eret               = ($urandom % 8 == 0);
        if ($urandom % 6 == 0) hardware_int = NHW'($urandom);
        software_int       = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
        interrupt_mask     = 8'($urandom);
        allow_int          = 1'($urandom);
        is_real_inst       = ($urandom % 4 != 0);
        pc_value           = $urandom;
        in_delayslot       = 1'($urandom);
        mem_access_vaddr   = $urandom;
        if_asid            = 8'($urandom);
        mm_asid            = 8'($urandom);
        ebase_in           = 20'($urandom);
        epc_in             = $urandom;
        special_int_vec    = 1'($urandom);
        boot_exp_vec       = 1'($urandom);
        if_exl             = 1'($urandom);
        mm_exl             = 1'($urandom);
        vint_en            = 1'($urandom);
        vint_spacing       = 5'($urandom);
        pipe_ready         = ($urandom % 3 == 0);
        rst_n              = ($urandom % 150 != 0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 32'h0);
        chk("rst_valid", exp_valid, 32'h0);
        chk("rst_new_pc", exception_new_pc, 32'h0);
        #1 rst_n = 1;

        @(negedge clk); #1;
        syscall = 1; pc_value = 32'h80001000; in_delayslot = 1; ebase_in = 20'h80000;
        @(negedge clk);
        chk("sys_flush", flush, 32'h1);
        chk("sys_code", exp_code, 32'h08);
        chk("sys_epc", exp_epc, 32'h80000FFC);
        chk("sys_pc", exception_new_pc, 32'h80000180);
        release_pipe();

        fetch_exp = 3'b010; if_exl = 0; pc_value = 32'h00400000; if_asid = 8'h3A; in_delayslot = 0;
        @(negedge clk);
        chk("fmiss_code", exp_code, 32'h02);
        chk("fmiss_pc", exception_new_pc, 32'h80000000);
        chk("fmiss_badv", exp_bad_vaddr, 32'h00400000);
        chk("fmiss_asid", exp_asid, 32'h3A);
        chk("fmiss_we", {cp0_badv_we, cp0_exp_asid_we}, 32'h3);
        release_pipe();
        fetch_exp = 3'b010; if_exl = 1; pc_value = 32'h00400000; if_asid = 8'h3A;
        @(negedge clk);
        chk("fmiss_exl_pc", exception_new_pc, 32'h80000180);
        release_pipe();

        interrupt_mask = 8'hFF; allow_int = 1; is_real_inst = 1; special_int_vec = 1;
        vint_en = 1; vint_spacing = 5'd1; boot_exp_vec = 1; hardware_int = 6'b001000;
        @(negedge clk);
        chk("vint_wait1", exp_valid, 32'h0);
        @(negedge clk);
        chk("vint_wait2", exp_valid, 32'h0);
        @(negedge clk);
        chk("vint_valid", exp_valid, 32'h1);
        chk("vint_pc", exception_new_pc, 32'hBFC004A0);
        chk("vint_code", exp_code, 32'h0);
        release_pipe();

        data_exp = 4'b0001; overflow = 1; data_we = 1; mem_access_vaddr = 32'h12345678; mm_asid = 8'h55;
        @(negedge clk);
        chk("prio_code", exp_code, 32'h01);
        chk("prio_asid", exp_asid, 32'h55);
        #1 clear_events();
        syscall = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_ignores", exp_valid, 32'h0);
        end
        #1 pipe_ready = 1;
        @(negedge clk);
        chk("ready_gap", exp_valid, 32'h0);
        #1 pipe_ready = 0;
        @(negedge clk);
        chk("post_ready_valid", exp_valid, 32'h1);
        chk("post_ready_code", exp_code, 32'h08);
        release_pipe();

        eret = 1; epc_in = 32'h80002000;
        @(negedge clk);
        chk("eret_pc", exception_new_pc, 32'h80002000);
        chk("eret_clean", cp0_clean_exl, 32'h1);
        chk("eret_in_exp", cp0_in_exp, 32'h0);
        chk("eret_flush", flush, 32'h1);
        release_pipe();

        syscall = 1;
        @(negedge clk);
        #1 clear_events();
        @(negedge clk);
        chk("wait_busy", busy, 32'h1);
        #1 rst_n = 0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 32'h0);
        chk("mid_rst_valid", exp_valid, 32'h0);
        chk("mid_rst_pc", exception_new_pc, 32'h0);
        chk("mid_rst_code", exp_code, 32'h0);
        #1 rst_n = 1; syscall = 1;
        @(negedge clk);
        chk("after_rst_valid", exp_valid, 32'h1);
        chk("after_rst_code", exp_code, 32'h08);
        release_pipe();

        repeat (3000) begin
            randomize_inputs();
            @(negedge clk);
            #1;
        end

        clear_events();
        rst_n = 1;
        pipe_ready = 1;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
